// File: rtl/dense_forward.sv
// dense_forward: sequential single-neuron dense evaluator.
// Computes y = bias + sum(weight[i] * x[i]) over `size` signed fixed-point
// elements, one multiply-accumulate per cycle, with a saturating conversion
// back to the data_size-bit format on the final MAC cycle.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE and never while rst is
// high. out_valid, once raised, holds with y/overflow stable until the edge
// where out_ready is seen high. Producers may change inputs freely after the
// accept edge; the operands are captured internally.
//
// Operation timeline: accept edge T0 loads the operands and the scaled bias.
// Edges T1..T(size) each add one product. The edge T(size) also registers
// the converted result and raises out_valid. The first edge with out_ready
// high returns the block to IDLE, so a new accept can land one cycle later.
module dense_forward #(
   parameter int size      = 3,
   parameter int data_size = 16,
   parameter int frac_bits = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [size*data_size-1:0] weight,
   input  logic [size*data_size-1:0] x,
   input  logic [data_size-1:0]      bias,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [data_size-1:0]      y,
   output logic                      overflow,
   output logic [1:0]                dbg_state
);

   // Element width, accumulator width and element-index width.
   // The accumulator carries full products plus enough guard bits to sum
   // size products and the scaled bias without wrapping.
   localparam int DW = data_size;
   localparam int PW = 2 * data_size;
   localparam int AW = 2 * data_size + $clog2(size + 1);
   localparam int IW = (size > 1) ? $clog2(size) : 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(size - 1);

   // Saturation limits of the output format, expressed at accumulator width.
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    r_state;
   logic [size*DW-1:0]        r_w;
   logic [size*DW-1:0]        r_x;
   logic signed [AW-1:0]      r_acc;
   logic [IW-1:0]             r_idx;
   logic                      r_out_valid;
   logic [DW-1:0]             r_y;
   logic                      r_ov;

   logic signed [DW-1:0]      w_w_elem;
   logic signed [DW-1:0]      w_x_elem;
   logic signed [PW-1:0]      w_prod;
   logic signed [AW-1:0]      w_prod_ext;
   logic signed [AW-1:0]      w_sum;
   logic signed [AW-1:0]      w_bias_ext;
   logic signed [AW-1:0]      w_acc_init;
   logic signed [AW-1:0]      w_shifted;
   logic [DW-1:0]             w_y_sat;
   logic                      w_ov;

   // Ready only while idle; reset always wins over an accept.
   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign overflow  = r_ov;
   assign dbg_state = r_state;

   // Pick the operand pair addressed by the current MAC index.
   always_comb begin
      w_w_elem = '0;
      w_x_elem = '0;
      for (int i = 0; i < size; i++) begin
         if (r_idx == IW'(i)) begin
            w_w_elem = r_w[i*DW +: DW];
            w_x_elem = r_x[i*DW +: DW];
         end
      end
   end

   // Full-width signed product and the running sum it feeds.
   always_comb begin
      w_prod     = w_w_elem * w_x_elem;
      w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
      w_sum      = r_acc + w_prod_ext;
   end

   // Bias moved into product scale (frac_bits more fractional bits).
   always_comb begin
      w_bias_ext = {{(AW-DW){bias[DW-1]}}, bias};
      w_acc_init = w_bias_ext <<< frac_bits;
   end

   // Final conversion: floor back to the data format, then clamp.
   always_comb begin
      w_shifted = w_sum >>> frac_bits;
      w_y_sat   = w_shifted[DW-1:0];
      w_ov      = 1'b0;
      if (w_shifted > SAT_MAX) begin
         w_y_sat = SAT_MAX[DW-1:0];
         w_ov    = 1'b1;
      end else if (w_shifted < SAT_MIN) begin
         w_y_sat = SAT_MIN[DW-1:0];
         w_ov    = 1'b1;
      end
   end

   // Control FSM with operand capture, MAC datapath and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_w         <= '0;
         r_x         <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_ov        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_w     <= weight;
                  r_x     <= x;
                  r_acc   <= w_acc_init;
                  r_idx   <= '0;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_sum;
               if (r_idx == LAST_IDX) begin
                  r_y         <= w_y_sat;
                  r_ov        <= w_ov;
                  r_out_valid <= 1'b1;
                  r_idx       <= '0;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            S_DONE: begin
               // Result is held until the consumer takes it; new requests wait.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dense_forward.md
Name: dense_forward

Overview:
- Forward-pass single-neuron dense evaluator: y = bias + sum(weight[i]*x[i]) over `size` signed fixed-point elements.
- Companion to the derivative blocks of the backprop path. Consumes the same packed `weight`/`x` vector format and produces the activation that the backward path later differentiates.
- Sequential: one MAC per cycle, valid/ready handshake on both input and output.

Parameters:
- size, 3, number of vector elements (>=1)
- data_size, 16, bit width of each signed element, bias and result
- frac_bits, 8, fractional bits of the fixed-point format (0 <= frac_bits < data_size)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  weight/x/bias valid
- in_ready  output  1  block can accept an operation
- weight  input  size*data_size  packed signed weights; element i at [i*data_size +: data_size]
- x  input  size*data_size  packed signed inputs, same packing
- bias  input  data_size  signed bias, same fixed-point format
- out_valid  output  1  y/overflow valid
- out_ready  input  1  consumer accepts the result
- y  output  data_size  saturated signed result
- overflow  output  1  y was saturated

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; out_valid=0, y=0, overflow=0; internal acc=0, idx=0.
  - in_ready=0 while rst is high.
  - Reset in any state aborts the operation; no out_valid is produced for it.
- Accumulator: signed, width 2*data_size+$clog2(size+1).
  - Products are full-width signed data_size x data_size.
  - Bias is sign-extended and shifted left by frac_bits into product scale.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1 (combinational from state, gated by rst).
  - On in_valid&&in_ready: latch weight, x, bias into internal registers; acc<=bias<<frac_bits; idx<=0; go to MAC.
  - Inputs may change after the accept edge without effect.
- MAC:
  - in_ready=0. Each edge: acc<=acc+w[idx]*x[idx]; idx<=idx+1.
  - On the edge where idx==size-1, the final sum (acc plus last product) is converted and registered into y/overflow, out_valid<=1, and state goes to DONE.
- Conversion:
  - Arithmetic shift right by frac_bits, i.e. truncation toward minus infinity.
  - Saturate to [-2^(data_size-1), 2^(data_size-1)-1].
  - overflow=1 if and only if clamping occurred.
- Latency: the accept edge is T0; out_valid is high after edge T(size). size=1 gives 1 cycle.
- DONE:
  - in_ready=0. y/overflow/out_valid hold stable while out_ready=0, for any number of cycles.
  - in_valid is ignored in this state.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. y and overflow keep their last values.
- No overlap: a new operation is accepted no earlier than the cycle after the output handshake. Throughput is 1 op per size+2 cycles with out_ready held high.
- Simultaneous rst and any handshake: rst wins.
- Unused states decode to IDLE.

Test Plan:
- Basic, size=3, frac_bits=8: weight={0x0100,0x0200,0xFF80}, x={0x0200,0x0080,0x0400}, bias=0x0040 -> y=0x0140 (1.25), overflow=0, out_valid 3 cycles after accept.
- Positive saturation: all weight=0x7FFF, all x=0x7FFF, bias=0x7FFF -> y=0x7FFF, overflow=1. Negative saturation: weight all 0x7FFF, x all 0x8000, bias 0x8000 -> y=0x8000, overflow=1.
- Truncation:
  - weight={0x0001,0,0}, x={0x0001,0,0}, bias=0 -> y=0x0000, overflow=0.
  - weight={0xFFFF,0,0}, x={0x0001,0,0}, bias=0 -> y=0xFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid pulsed high.
  - y/overflow stable, in_ready=0, pulsed op not accepted.
  - Release out_ready -> one transfer, then in_ready=1 next cycle.
- Reset mid-MAC: assert rst for 1 cycle at idx=1 -> out_valid never rises for that op, y=0. Next op (basic vector) returns 0x0140 with normal latency.
- Back-to-back: out_ready tied 1, in_valid tied 1 with two different vectors -> accepts spaced exactly size+2 cycles, both results correct.
